// File: rtl/seg_decoder_if.sv
// Multiplexed 7-segment bus seen by seg_decoder: active-low segment lines and digit strobes.
interface seg_decoder_if #(
  parameter int NUM_DIGITS = 6
);
  logic [7:0]            seg_in;
  logic [NUM_DIGITS-1:0] an_in;

  modport master (output seg_in, output an_in);
  modport slave  (input  seg_in, input  an_in);
endinterface

// File: rtl/seg_decoder.sv
// Recovers per-digit symbol codes from a scanned 7-segment bus with a stability filter.
// Optional SEG_DECODE_DP_EN: treat seg_in[7] as decimal point and report it on dp_out.
module seg_decoder #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg_decoder_if.slave            bus,
  output logic [5*NUM_DIGITS-1:0] code_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update_pulse,
  output logic [IDX_W-1:0]        update_idx,
  output logic                    err_pulse,
  output logic [NUM_DIGITS-1:0]   dp_out
);
  // state   | meaning
  // IDLE    | bus unchanged since reset
  // SETTLE  | sample changed, counting identical samples
  // CAPTURE | sample stable long enough, decode and store this cycle
  // HOLD    | captured; wait for the next change before settling again
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t                state;
  logic [7:0]            seg_s1, seg_s2, seg_prev;
  logic [NUM_DIGITS-1:0] an_s1, an_s2, an_prev;
  logic [CNT_W-1:0]      cnt;
  logic                  change;
  logic [NUM_DIGITS-1:0] an_low;
  logic                  an_onehot;
  logic [IDX_W-1:0]      an_idx;
  logic [7:0]            key;
  logic                  dec_ok;
  logic [4:0]            dec_code;

  assign change = (seg_s2 != seg_prev) || (an_s2 != an_prev);

  always_comb begin
    an_low    = ~an_prev;
    an_onehot = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
    an_idx    = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (an_low[i]) an_idx = IDX_W'(i);
  end

`ifdef SEG_DECODE_DP_EN
  // Table entries all have bit7 set, so forcing it high matches on the 7 segment lines only.
  assign key = {1'b1, seg_prev[6:0]};
`else
  assign key = seg_prev;
`endif

  always_comb begin
    dec_ok   = 1'b1;
    dec_code = 5'd19;
    case (key)
      8'hC0: dec_code = 5'd0;
      8'hF9: dec_code = 5'd1;
      8'hA4: dec_code = 5'd2;
      8'hB0: dec_code = 5'd3;
      8'h99: dec_code = 5'd4;
      8'h92: dec_code = 5'd5;
      8'h82: dec_code = 5'd6;
      8'hF8: dec_code = 5'd7;
      8'h80: dec_code = 5'd8;
      8'h90: dec_code = 5'd9;
      8'h88: dec_code = 5'd10;
      8'h83: dec_code = 5'd11;
      8'hC6: dec_code = 5'd12;
      8'hA1: dec_code = 5'd13;
      8'h86: dec_code = 5'd14;
      8'h8E: dec_code = 5'd15;
      8'hAF: dec_code = 5'd16;
      8'h87: dec_code = 5'd18;
      8'hFF: dec_code = 5'd19;
      default: dec_ok = 1'b0;
    endcase
  end

`ifdef SEG_DECODE_DP_EN
  logic [NUM_DIGITS-1:0] dp_r;
  assign dp_out = dp_r;
`else
  assign dp_out = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1       <= '1;
      seg_s2       <= '1;
      seg_prev     <= '1;
      an_s1        <= '1;
      an_s2        <= '1;
      an_prev      <= '1;
      cnt          <= '0;
      state        <= IDLE;
      code_out     <= {NUM_DIGITS{5'd19}};
      digit_valid  <= '0;
      update_pulse <= 1'b0;
      update_idx   <= '0;
      err_pulse    <= 1'b0;
`ifdef SEG_DECODE_DP_EN
      dp_r         <= '0;
`endif
    end else begin
      seg_s1       <= bus.seg_in;
      seg_s2       <= seg_s1;
      seg_prev     <= seg_s2;
      an_s1        <= bus.an_in;
      an_s2        <= an_s1;
      an_prev      <= an_s2;
      update_pulse <= 1'b0;
      err_pulse    <= 1'b0;

      if (change) cnt <= '0;
      else if (cnt < CNT_W'(STABLE_CYCLES)) cnt <= cnt + CNT_W'(1);

      case (state)
        IDLE:   if (change) state <= SETTLE;
        // Leave on the edge where the count reaches STABLE_CYCLES.
        SETTLE: if (!change && cnt == CNT_W'(STABLE_CYCLES - 1)) state <= CAPTURE;
        CAPTURE: begin
          state <= change ? SETTLE : HOLD;
          if (an_onehot) begin
            if (dec_ok) begin
              code_out[5*an_idx +: 5] <= dec_code;
              digit_valid[an_idx]     <= 1'b1;
              update_pulse            <= 1'b1;
              update_idx              <= an_idx;
`ifdef SEG_DECODE_DP_EN
              dp_r[an_idx]            <= ~seg_prev[7];
`endif
            end else begin
              err_pulse <= 1'b1;
            end
          end
        end
        HOLD:   if (change) state <= SETTLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
